// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives instruction memory, and
// registers the fetched word into the IF/ID pipeline register.
//   clk_i           : clock, all state updates on rising edge
//   rst_i           : asynchronous active-low reset
//   stall_i         : hold PC and IF/ID (load-use hazard)
//   redirect_i      : taken branch/jump resolved downstream (wins over stall)
//   redirect_pc_i   : redirect target (low two bits ignored)
//   imem_addr_o     : instruction memory address (current PC)
//   imem_instr_i    : instruction word for imem_addr_o, same cycle
//   ifid_instr_o    : registered instruction for the decoder
//   ifid_pc_o       : PC of ifid_instr_o
//   ifid_pc4_o      : ifid_pc_o + 4 (link value)
//   ifid_valid_o    : 1 = real instruction, 0 = bubble
//   fetch_cnt_o     : number of valid instructions delivered
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_instr_i,
  output logic [31:0] ifid_instr_o,
  output logic [31:0] ifid_pc_o,
  output logic [31:0] ifid_pc4_o,
  output logic        ifid_valid_o,
  output logic [31:0] fetch_cnt_o
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned OPW  = 7;

  typedef enum logic {
    S_BOOT = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [XLEN-1:0]   ifpc_q, ifpc_d;
  logic              valid_q, valid_d;
  logic [XLEN-1:0]   cnt_q, cnt_d;
  logic [OPW-1:0]    opcode;
  logic              legal_op;

  // Only opcodes the decoder understands may pass as valid instructions
  always_comb begin
    opcode   = imem_instr_i[OPW-1:0];
    legal_op = 1'b0;
    case (opcode)
      7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011,
      7'b0010011, 7'b1101111, 7'b1100111: legal_op = 1'b1;
      default:                            legal_op = 1'b0;
    endcase
  end

  // Next-state: BOOT inserts one bubble; RUN is redirect > stall > advance
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_BOOT: begin
        state_d = S_RUN;
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end
      S_RUN: begin
        if (redirect_i) begin
          pc_d    = {redirect_pc_i[XLEN-1:2], 2'b00};
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end else if (!stall_i) begin
          pc_d   = pc_q + XLEN'(4);
          ifpc_d = pc_q;
          if (legal_op) begin
            instr_d = imem_instr_i;
            valid_d = 1'b1;
            cnt_d   = cnt_q + XLEN'(1);
          end else begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
          end
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  // State and pipeline registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      ifpc_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_addr_o  = pc_q;
  assign ifid_instr_o = instr_q;
  assign ifid_pc_o    = ifpc_q;
  assign ifid_pc4_o   = ifpc_q + XLEN'(4);
  assign ifid_valid_o = valid_q;
  assign fetch_cnt_o  = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized
// stall/redirect/reset traffic checked against a behavioural model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_instr_i;
  logic [31:0] ifid_instr_o;
  logic [31:0] ifid_pc_o;
  logic [31:0] ifid_pc4_o;
  logic        ifid_valid_o;
  logic [31:0] fetch_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  fetch_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .imem_addr_o(imem_addr_o),
    .imem_instr_i(imem_instr_i), .ifid_instr_o(ifid_instr_o),
    .ifid_pc_o(ifid_pc_o), .ifid_pc4_o(ifid_pc4_o),
    .ifid_valid_o(ifid_valid_o), .fetch_cnt_o(fetch_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Instruction memory: a few pinned words, otherwise a hashed mix of legal and illegal opcodes
  function automatic logic [31:0] mem(input logic [31:0] a);
    logic [31:0] h;
    logic [6:0]  op;
    case (a)
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_0004: return 32'h0010_0113;
      32'h0000_0010: return 32'h0020_8133;
      32'h0000_0200: return 32'h0000_007F;
      32'hFFFF_FFFC: return 32'h00A0_0093;
      default: ;
    endcase
    h = (a * 32'h9E37_79B1) ^ (a >> 7);
    case (h[3:0])
      4'd0:    op = 7'b0110011;
      4'd1:    op = 7'b0000011;
      4'd2:    op = 7'b0100011;
      4'd3:    op = 7'b1100011;
      4'd4:    op = 7'b1101111;
      4'd5:    op = 7'b1100111;
      4'd6:    op = 7'h7F;
      4'd7:    op = 7'h37;
      4'd8:    op = 7'h00;
      default: op = 7'b0010011;
    endcase
    return {h[31:7], op};
  endfunction

  function automatic bit is_legal(input logic [31:0] w);
    return w[6:0] inside {7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011,
                          7'b0010011, 7'b1101111, 7'b1100111};
  endfunction

  assign imem_instr_i = mem(imem_addr_o);

  // Behavioural model of the architectural fetch state
  bit          m_boot  = 1'b1;
  logic [31:0] m_pc    = '0;
  logic [31:0] m_instr = NOP;
  logic [31:0] m_ifpc  = '0;
  bit          m_valid = 1'b0;
  logic [31:0] m_cnt   = '0;

  always @(posedge clk_i or negedge rst_i) begin
    logic [31:0] w;
    if (!rst_i) begin
      m_boot = 1'b1; m_pc = '0; m_instr = NOP; m_ifpc = '0; m_valid = 1'b0; m_cnt = '0;
    end else if (m_boot) begin
      m_boot = 1'b0; m_instr = NOP; m_valid = 1'b0;
    end else if (redirect_i) begin
      m_pc = redirect_pc_i & 32'hFFFF_FFFC; m_instr = NOP; m_valid = 1'b0;
    end else if (!stall_i) begin
      w = mem(m_pc);
      m_ifpc = m_pc;
      if (is_legal(w)) begin
        m_instr = w; m_valid = 1'b1; m_cnt = m_cnt + 1;
      end else begin
        m_instr = NOP; m_valid = 1'b0;
      end
      m_pc = m_pc + 4;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h want %08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model compare on every falling edge
  always @(negedge clk_i) begin
    if (cmp_en) begin
      chk("m.imem_addr", imem_addr_o, m_pc);
      chk("m.ifid_valid", 32'(ifid_valid_o), 32'(m_valid));
      chk("m.ifid_instr", ifid_instr_o, m_instr);
      if (m_valid) chk("m.ifid_pc", ifid_pc_o, m_ifpc);
      chk("m.ifid_pc4", ifid_pc4_o, ifid_pc_o + 32'd4);
      chk("m.fetch_cnt", fetch_cnt_o, m_cnt);
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input bit st, input bit rd, input logic [31:0] tgt);
    stall_i = st; redirect_i = rd; redirect_pc_i = tgt;
  endtask

  initial begin
    logic [31:0] tgt;
    rst_i = 1'b1;
    #1 rst_i = 1'b0;
    #1 cmp_en = 1'b1;
    // Reset values
    chk("rst.addr", imem_addr_o, 32'h0);
    chk("rst.instr", ifid_instr_o, NOP);
    chk("rst.valid", 32'(ifid_valid_o), 32'h0);
    chk("rst.pc", ifid_pc_o, 32'h0);
    chk("rst.cnt", fetch_cnt_o, 32'h0);
    step(); step();
    rst_i = 1'b1;
    // Boot bubble then first two fetches
    step();
    chk("boot.valid", 32'(ifid_valid_o), 32'h0);
    chk("boot.addr", imem_addr_o, 32'h0);
    step();
    chk("f1.instr", ifid_instr_o, 32'h0050_0093);
    chk("f1.pc", ifid_pc_o, 32'h0);
    chk("f1.valid", 32'(ifid_valid_o), 32'h1);
    step();
    chk("f2.instr", ifid_instr_o, 32'h0010_0113);
    chk("f2.pc", ifid_pc_o, 32'h4);
    chk("f2.cnt", fetch_cnt_o, 32'd2);
    // Stall three cycles at PC 0x10
    drive(0, 1, 32'h10); step();
    drive(1, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall.addr", imem_addr_o, 32'h10);
      chk("stall.cnt", fetch_cnt_o, 32'd2);
      chk("stall.valid", 32'(ifid_valid_o), 32'h0);
    end
    drive(0, 0, 32'h0); step();
    chk("resume.addr", imem_addr_o, 32'h14);
    chk("resume.pc", ifid_pc_o, 32'h10);
    chk("resume.cnt", fetch_cnt_o, 32'd3);
    // Redirect wins over stall and aligns target
    drive(1, 1, 32'h0000_0102); step();
    chk("redir.addr", imem_addr_o, 32'h100);
    chk("redir.valid", 32'(ifid_valid_o), 32'h0);
    chk("redir.instr", ifid_instr_o, NOP);
    // PC wrap
    drive(0, 1, 32'hFFFF_FFFC); step();
    drive(0, 0, 32'h0); step();
    chk("wrap.addr", imem_addr_o, 32'h0);
    chk("wrap.pc", ifid_pc_o, 32'hFFFF_FFFC);
    chk("wrap.pc4", ifid_pc4_o, 32'h0);
    chk("wrap.cnt", fetch_cnt_o, 32'd4);
    // Illegal opcode becomes a bubble
    drive(0, 1, 32'h200); step();
    drive(0, 0, 32'h0); step();
    chk("ill.instr", ifid_instr_o, NOP);
    chk("ill.valid", 32'(ifid_valid_o), 32'h0);
    chk("ill.cnt", fetch_cnt_o, 32'd4);
    chk("ill.addr", imem_addr_o, 32'h204);
    // Asynchronous reset pulse between edges
    drive(0, 1, 32'h40); step();
    chk("pre.addr", imem_addr_o, 32'h40);
    drive(1, 1, 32'h80);
    #1 rst_i = 1'b0;
    #1;
    chk("arst.addr", imem_addr_o, 32'h0);
    chk("arst.cnt", fetch_cnt_o, 32'h0);
    chk("arst.instr", ifid_instr_o, NOP);
    rst_i = 1'b1;
    drive(0, 0, 32'h0); step();
    chk("arst.boot.addr", imem_addr_o, 32'h0);
    chk("arst.boot.valid", 32'(ifid_valid_o), 32'h0);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tgt = $urandom;
      if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFE0 | (tgt & 32'h1F);
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, tgt);
      step();
      if ($urandom_range(0, 199) == 0) begin
        #1 rst_i = 1'b0;
        #1 rst_i = 1'b1;
      end
    end
    drive(0, 0, 32'h0);
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
